// File: rtl/whack_pkg.sv
// Shared types and constants for the round-timer seven-segment display path.
package whack_pkg;

    localparam int unsigned MAX_SECONDS_DEF = 60;
    localparam int unsigned BIN_W = 6;
    localparam int unsigned BCD_W = 8;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned AN_W  = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_e;

    // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit
    function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd6.sv
// Sequential shift-add-3 converter: 6-bit binary to two BCD digits, with range flag.
module bin2bcd6
    import whack_pkg::*;
#(
    parameter int unsigned MAX_SECONDS = MAX_SECONDS_DEF
) (
    input  logic             clk_o,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             accept_c,
    output logic             done_c,
    output logic [BCD_W-1:0] bcd,
    output logic             err,
    output logic             busy
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

    conv_state_e      state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [BCD_W-1:0] adj;

    always_ff @(posedge clk_o or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        accept_c = 1'b0;
        done_c   = 1'b0;
        adj      = bcd_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    bin_d    = bin_in;
                    err_d    = 32'(bin_in) > MAX_SECONDS;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
                if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
                {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                done_c = 1'b1;
                // A waiting value restarts the conversion without passing through IDLE
                if (start) begin
                    accept_c = 1'b1;
                    bin_d    = bin_in;
                    err_d    = 32'(bin_in) > MAX_SECONDS;
                    state_d  = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bcd  = bcd_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: rtl/round_time_display.sv
// Seconds-count display: pending capture, BCD conversion, and 4-digit multiplexed scan.
module round_time_display
    import whack_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned MAX_SECONDS = MAX_SECONDS_DEF
) (
    input  logic             clk_o,
    input  logic             rst,
    input  logic [BIN_W-1:0] count,
    input  logic             count_valid,
    output logic [SEG_W-1:0] seg,
    output logic [AN_W-1:0]  an,
    output logic             dp,
    output logic             time_up,
    output logic             count_err,
    output logic             busy
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);

    logic             pend_valid_q, pend_valid_d;
    logic [BIN_W-1:0] pend_val_q, pend_val_d;
    logic             disp_valid_q, disp_valid_d;
    logic             disp_err_q, disp_err_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             time_up_q, time_up_d;
    logic             count_err_q, count_err_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [AN_W-1:0]  an_q, an_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [SEG_W-1:0] digit_seg_c;

    logic             accept_c;
    logic             done_c;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_err;

    bin2bcd6 #(
        .MAX_SECONDS(MAX_SECONDS)
    ) u_conv (
        .clk_o    (clk_o),
        .rst      (rst),
        .start    (pend_valid_q),
        .bin_in   (pend_val_q),
        .accept_c (accept_c),
        .done_c   (done_c),
        .bcd      (conv_bcd),
        .err      (conv_err),
        .busy     (busy)
    );

    always_ff @(posedge clk_o or negedge rst) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_val_q   <= '0;
            disp_valid_q <= 1'b0;
            disp_err_q   <= 1'b0;
            tens_q       <= '0;
            ones_q       <= '0;
            time_up_q    <= 1'b0;
            count_err_q  <= 1'b0;
            rcnt_q       <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_val_q   <= pend_val_d;
            disp_valid_q <= disp_valid_d;
            disp_err_q   <= disp_err_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            time_up_q    <= time_up_d;
            count_err_q  <= count_err_d;
            rcnt_q       <= rcnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    // Segment pattern of the digit currently selected by the scan index
    always_comb begin
        digit_seg_c = SEG_BLANK;
        if (disp_valid_q) begin
            case (idx_q)
                2'd0:    digit_seg_c = disp_err_q ? SEG_DASH : seg_digit(ones_q);
                2'd1:    digit_seg_c = disp_err_q ? SEG_DASH :
                                       ((tens_q == 4'd0) ? SEG_BLANK : seg_digit(tens_q));
                default: digit_seg_c = SEG_BLANK;
            endcase
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_val_d   = pend_val_q;
        disp_valid_d = disp_valid_q;
        disp_err_d   = disp_err_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        time_up_d    = time_up_q;
        count_err_d  = count_err_q;
        rcnt_d       = rcnt_q + RW'(1);
        idx_d        = idx_q;
        an_d         = an_q;
        seg_d        = seg_q;

        // A fresh strobe always wins over the converter consuming the old value
        if (count_valid) begin
            pend_valid_d = 1'b1;
            pend_val_d   = count;
        end else if (accept_c) begin
            pend_valid_d = 1'b0;
        end

        if (done_c) begin
            disp_valid_d = 1'b1;
            disp_err_d   = conv_err;
            tens_d       = conv_bcd[7:4];
            ones_d       = conv_bcd[3:0];
            time_up_d    = (conv_bcd == '0) && !conv_err;
            count_err_d  = conv_err;
        end

        if (rcnt_q == RCNT_LAST) begin
            rcnt_d = '0;
            idx_d  = idx_q + 2'd1;
            an_d   = ~(AN_W'(1) << idx_q);
            seg_d  = digit_seg_c;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign dp        = 1'b1;
    assign time_up   = time_up_q;
    assign count_err = count_err_q;

endmodule

// File: tb/tb_round_time_display.sv
// Directed bench for round_time_display with a commit scoreboard and a scan model.
module tb_round_time_display;

    logic       clk_o = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] count = '0;
    logic       count_valid = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       time_up;
    logic       count_err;
    logic       busy;

    round_time_display #(
        .REFRESH_DIV(4),
        .MAX_SECONDS(60)
    ) dut (
        .clk_o       (clk_o),
        .rst         (rst),
        .count       (count),
        .count_valid (count_valid),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .time_up     (time_up),
        .count_err   (count_err),
        .busy        (busy)
    );

    always #5 clk_o = ~clk_o;

    typedef struct {
        int unsigned val;
        bit          err;
        bit          tu;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [6:0]  enc[10];
    bit          m_valid, m_err;
    int          m_tens, m_ones;
    int          rcnt_m, idx_m;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    bit          exp_tu, exp_ce;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] model_digit(input int i);
        if (!m_valid || i > 1) return 7'h7F;
        if (m_err) return 7'h3F;
        if (i == 0) return enc[m_ones];
        return (m_tens == 0) ? 7'h7F : enc[m_tens];
    endfunction

    task automatic model_reset();
        m_valid = 0; m_err = 0; m_tens = 0; m_ones = 0;
        rcnt_m = 0; idx_m = 0;
        exp_an = 4'hF; exp_seg = 7'h7F;
        exp_tu = 0; exp_ce = 0;
        sb.delete();
    endtask

    // One clock; scan outputs checked against the model every cycle
    task automatic tick();
        if (rcnt_m == 3) begin
            exp_an  = ~(4'b0001 << idx_m);
            exp_seg = model_digit(idx_m);
            idx_m   = (idx_m + 1) % 4;
            rcnt_m  = 0;
        end else begin
            rcnt_m++;
        end
        @(posedge clk_o);
        #1;
        chk("scan_an", 32'(an), 32'(exp_an));
        chk("scan_seg", 32'(seg), 32'(exp_seg));
        chk("dp", 32'(dp), 32'd1);
    endtask

    task automatic strobe(input int v, input bit push);
        count       = 6'(v);
        count_valid = 1'b1;
        if (push) sb.push_back('{val: v, err: (v > 60), tu: (v == 0)});
        tick();
        count_valid = 1'b0;
    endtask

    task automatic flags(input string tag);
        chk({tag, "_time_up"}, 32'(time_up), 32'(exp_tu));
        chk({tag, "_count_err"}, 32'(count_err), 32'(exp_ce));
    endtask

    task automatic commit_check();
        exp_t rec;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_empty observed=empty expected=entry");
        end else begin
            rec     = sb.pop_front();
            exp_tu  = rec.tu;
            exp_ce  = rec.err;
            m_valid = 1;
            m_err   = rec.err;
            m_tens  = int'(rec.val / 10);
            m_ones  = int'(rec.val % 10);
            flags("commit");
        end
    endtask

    // Strobe at edge N, flags unchanged through N+8, committed at N+9
    task automatic convert(input int v);
        strobe(v, 1);
        repeat (7) tick();
        tick();
        flags("pre_commit");
        chk("busy_n8", 32'(busy), 32'd1);
        tick();
        commit_check();
        chk("busy_n9", 32'(busy), 32'd0);
    endtask

    initial begin
        enc = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        model_reset();
        #1 rst = 1'b0;
        #11;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'd1);
        flags("rst");
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk_o);
        #1 rst = 1'b1;
        model_reset();

        // Blank scan walking all four anodes
        repeat (20) tick();

        convert(60); repeat (16) tick();
        convert(7);  repeat (16) tick();
        convert(0);  repeat (16) tick();
        convert(63); repeat (16) tick();
        convert(45); repeat (16) tick();

        // Pending overwrite: 59 shown, then 57; 58 never reaches the display
        strobe(59, 1);
        tick(); tick();
        strobe(58, 0);
        tick();
        strobe(57, 1);
        repeat (3) tick();
        tick();
        commit_check();
        chk("busy_chain", 32'(busy), 32'd1);
        repeat (7) tick();
        flags("pre_commit57");
        tick();
        commit_check();
        chk("busy_after57", 32'(busy), 32'd0);
        repeat (16) tick();

        // Strobe coinciding with COMMIT goes to pending
        strobe(12, 1);
        repeat (7) tick();
        tick();
        strobe(0, 1);
        commit_check();
        repeat (8) tick();
        chk("busy_collide", 32'(busy), 32'd1);
        flags("pre_commit0");
        tick();
        commit_check();
        repeat (16) tick();

        // Reset in the middle of SHIFT
        strobe(25, 1);
        repeat (4) tick();
        rst = 1'b0;
        #1;
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_time_up", 32'(time_up), 32'd0);
        chk("midrst_count_err", 32'(count_err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk_o);
        #1 rst = 1'b1;
        model_reset();
        repeat (24) tick();
        flags("post_rst");
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
